// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       fifo_almost_full,
    output logic                       fifo_almost_empty,
    output logic                       fifo_overflow,
    output logic                       fifo_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_af;
    logic                  r_ae;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CW-1:0]         w_count_nxt;

    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    // Simultaneous accepted read and write leaves occupancy unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == LP_DEPTH);
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= LP_AF);
            r_ae    <= (w_count_nxt <= LP_AE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign data_out = r_data_out;
`endif

    assign fifo_count        = r_count;
    assign fifo_full         = r_full;
    assign fifo_empty        = r_empty;
    assign fifo_almost_full  = r_af;
    assign fifo_almost_empty = r_ae;
    assign fifo_overflow     = rst & wr_en & r_full;
    assign fifo_underflow    = rst & rd_en & r_empty;

endmodule
